// File: rtl/apb_timer_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_mc_pkg
// Description : Shared definitions for the multi-channel APB timer. Holds the
//               register offsets, the CTRL bit positions and the packed CTRL
//               view used by the channel and top-level files.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_timer_mc_pkg;

    // Per-channel register offsets, relative to the channel base.
    localparam logic [3:0] CTRL_OFF     = 4'h0;
    localparam logic [3:0] PRESC_OFF    = 4'h4;
    localparam logic [3:0] CMP_OFF      = 4'h8;
    localparam logic [3:0] COUNT_OFF    = 4'hC;

    // Global registers and channel spacing, in the decoded 9-bit window.
    localparam logic [8:0] STATUS_ADDR  = 9'h100;
    localparam logic [8:0] IRQ_RAW_ADDR = 9'h104;
    localparam logic [8:0] CH_STRIDE    = 9'h010;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AR_BIT          = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;

    // Field order follows the bit positions above (en is bit 0).
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage : apb_timer_mc_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One timer channel: CTRL/PRESC/CMP/COUNT registers, prescaler,
//               compare match and status-set pulse.
//               Optional registered PWM output when APB_TIMER_MC_PWM_EN is
//               defined.
// Ports       : clk, rst (sync, active-high)
//               i_*_we      - per-register write strobes
//               i_wdata     - APB write data
//               o_ctrl/o_presc/o_cmp/o_count - register values for read-back
//               o_set_status - one-cycle pulse on a compare match tick
//               o_pwm       - (APB_TIMER_MC_PWM_EN only) EN && COUNT<CMP
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import apb_timer_mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ctrl_we,
    input  logic               i_presc_we,
    input  logic               i_cmp_we,
    input  logic               i_count_we,
    input  logic [31:0]        i_wdata,
    output ctrl_t              o_ctrl,
    output logic [PRESC_W-1:0] o_presc,
    output logic [CNT_W-1:0]   o_cmp,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_set_status
`ifdef APB_TIMER_MC_PWM_EN
    ,
    output logic               o_pwm
`endif
);

    ctrl_t              r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_cmp;
    logic [CNT_W-1:0]   r_count;
    logic               w_tick;
    logic               w_match;
    logic               w_unused_wdata;

    assign w_tick  = r_ctrl.en && (r_presc_cnt == r_presc);
    assign w_match = w_tick && (r_count == r_cmp);

    // Narrow CNT_W/PRESC_W configurations leave upper data bits unread.
    assign w_unused_wdata = ^i_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_cmp       <= '0;
            r_count     <= '0;
        end else begin
            if (i_presc_we) begin
                r_presc <= i_wdata[PRESC_W-1:0];
            end
            if (i_cmp_we) begin
                r_cmp <= i_wdata[CNT_W-1:0];
            end

            // Prescaler parks at 0 while disabled so enabling starts a full period.
            if (i_presc_we || !r_ctrl.en || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end

            // A bus write to COUNT overrides whatever the tick would do.
            if (i_count_we) begin
                r_count <= i_wdata[CNT_W-1:0];
            end else if (w_tick) begin
                if (r_count == r_cmp) begin
                    if (r_ctrl.auto_reload) begin
                        r_count <= '0;
                    end
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            // A CTRL write beats the one-shot self-clear of EN.
            if (i_ctrl_we) begin
                r_ctrl.en          <= i_wdata[CTRL_EN_BIT];
                r_ctrl.auto_reload <= i_wdata[CTRL_AR_BIT];
                r_ctrl.irq_en      <= i_wdata[CTRL_IRQ_EN_BIT];
            end else if (w_match && !r_ctrl.auto_reload) begin
                r_ctrl.en <= 1'b0;
            end
        end
    end

`ifdef APB_TIMER_MC_PWM_EN
    logic r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= r_ctrl.en && (r_count < r_cmp);
        end
    end

    assign o_pwm = r_pwm;
`endif

    assign o_ctrl       = r_ctrl;
    assign o_presc      = r_presc;
    assign o_cmp        = r_cmp;
    assign o_count      = r_count;
    assign o_set_status = w_match;

endmodule : timer_channel
`default_nettype wire

// File: rtl/apb_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_mc
// Description : Multi-channel APB timer. N_CH independent prescaled up-counters
//               with compare, one-shot/auto-reload, sticky W1C status and
//               per-channel interrupt enable.
//               Optional feature macro: APB_TIMER_MC_PWM_EN (adds pwm_o).
// Ports       : HCLK, HRESETn (sync, active-low)
//               PADDR/PWDATA/PWRITE/PSEL/PENABLE - APB slave inputs
//               PRDATA/PREADY/PSLVERR            - APB slave outputs
//               irq_ch_o - STATUS & IRQ_EN per channel
//               irq_o    - OR of irq_ch_o
//               pwm_o    - (APB_TIMER_MC_PWM_EN only) per-channel PWM
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_mc
    import apb_timer_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int N_CH           = 4,
    parameter int CNT_W          = 32,
    parameter int PRESC_W        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_CH-1:0]           irq_ch_o,
    output logic                      irq_o
`ifdef APB_TIMER_MC_PWM_EN
    ,
    output logic [N_CH-1:0]           pwm_o
`endif
);

    logic                      w_rst;
    logic                      w_access;
    logic                      w_wr;
    logic                      w_rd;
    logic [8:0]                w_off;
    logic [3:0]                w_reg_off;
    logic                      w_is_status;
    logic                      w_is_irq_raw;
    logic                      w_mapped;
    logic [N_CH-1:0]           w_ch_hit;
    logic [N_CH-1:0]           w_set;
    logic [N_CH-1:0]           w_irq_en;
    logic [N_CH-1:0]           w_clr;
    logic [N_CH-1:0]           r_status;
    logic [APB_DATA_WIDTH-1:0] w_rdata;
    logic                      w_unused_addr;

    ctrl_t                     w_ctrl  [N_CH];
    logic [PRESC_W-1:0]        w_presc [N_CH];
    logic [CNT_W-1:0]          w_cmp   [N_CH];
    logic [CNT_W-1:0]          w_count [N_CH];

    assign w_rst         = ~HRESETn;
    assign w_access      = PSEL & PENABLE;
    assign w_wr          = w_access & PWRITE;
    assign w_rd          = w_access & ~PWRITE;
    // Only [8:2] select a register; byte lanes and upper bits are don't-care.
    assign w_off         = {PADDR[8:2], 2'b00};
    assign w_reg_off     = w_off[3:0];
    assign w_is_status   = (w_off == STATUS_ADDR);
    assign w_is_irq_raw  = (w_off == IRQ_RAW_ADDR);
    assign w_mapped      = (|w_ch_hit) | w_is_status | w_is_irq_raw;
    assign w_unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:9], PADDR[1:0]};

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            assign w_ch_hit[c] = ({w_off[8:4], 4'h0} == 9'(c * CH_STRIDE));
            assign w_irq_en[c] = w_ctrl[c].irq_en;

            timer_channel #(
                .CNT_W   (CNT_W),
                .PRESC_W (PRESC_W)
            ) u_ch (
                .clk          (HCLK),
                .rst          (w_rst),
                .i_ctrl_we    (w_wr & w_ch_hit[c] & (w_reg_off == CTRL_OFF)),
                .i_presc_we   (w_wr & w_ch_hit[c] & (w_reg_off == PRESC_OFF)),
                .i_cmp_we     (w_wr & w_ch_hit[c] & (w_reg_off == CMP_OFF)),
                .i_count_we   (w_wr & w_ch_hit[c] & (w_reg_off == COUNT_OFF)),
                .i_wdata      (PWDATA),
                .o_ctrl       (w_ctrl[c]),
                .o_presc      (w_presc[c]),
                .o_cmp        (w_cmp[c]),
                .o_count      (w_count[c]),
                .o_set_status (w_set[c])
`ifdef APB_TIMER_MC_PWM_EN
                ,
                .o_pwm        (pwm_o[c])
`endif
            );
        end
    endgenerate

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    assign w_clr = (w_wr && w_is_status) ? PWDATA[N_CH-1:0] : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_status <= '0;
        end else begin
            r_status <= w_set | (r_status & ~w_clr);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_is_status) begin
                w_rdata = APB_DATA_WIDTH'(r_status);
            end else if (w_is_irq_raw) begin
                w_rdata = APB_DATA_WIDTH'(r_status & w_irq_en);
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (w_ch_hit[c]) begin
                        case (w_reg_off)
                            CTRL_OFF:  w_rdata = APB_DATA_WIDTH'(w_ctrl[c]);
                            PRESC_OFF: w_rdata = APB_DATA_WIDTH'(w_presc[c]);
                            CMP_OFF:   w_rdata = APB_DATA_WIDTH'(w_cmp[c]);
                            COUNT_OFF: w_rdata = APB_DATA_WIDTH'(w_count[c]);
                            default:   w_rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign PRDATA   = w_rdata;
    assign PREADY   = 1'b1;
    assign PSLVERR  = w_access & (~w_mapped | (PWRITE & w_is_irq_raw));
    assign irq_ch_o = r_status & w_irq_en;
    assign irq_o    = |irq_ch_o;

endmodule : apb_timer_mc
`default_nettype wire

// File: tb/tb_apb_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer_mc
// Description : Directed self-checking bench for apb_timer_mc (default
//               parameters). Covers reset, auto-reload, one-shot with
//               prescaler, set/clear and write/tick collisions, error
//               responses and, with APB_TIMER_MC_PWM_EN, the PWM output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_timer_mc;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic        PWRITE  = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  irq_ch_o;
    logic        irq_o;
`ifdef APB_TIMER_MC_PWM_EN
    logic [3:0]  pwm_o;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rd;
    logic        err;

    always #5 HCLK = ~HCLK;

    apb_timer_mc dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .irq_ch_o (irq_ch_o),
        .irq_o    (irq_o)
`ifdef APB_TIMER_MC_PWM_EN
        ,
        .pwm_o    (pwm_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Setup + access phase; the write lands on the edge ending the access.
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        step();
        PENABLE = 1'b1;
        #3 e = PSLVERR;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        step();
        PENABLE = 1'b1;
        #3 d = PRDATA; e = PSLVERR;
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        repeat (2) step();
        HRESETn = 1'b1;
        step();
        #3;
        chk("por_irq", irq_o, 0);
        chk("por_pready", PREADY, 1);
        chk("por_slverr", PSLVERR, 0);
        apb_rd(12'h00C, rd, err);
        chk("por_count0", rd, 0);

        // ---------------- ch0 auto-reload, PRESC=0, CMP=3 ----------------
        apb_wr(12'h004, 32'd0, err);
        apb_wr(12'h008, 32'd3, err);
        apb_wr(12'h000, 32'h7, err);
        chk("ar_ctrl_err", err, 0);
        // Hold a read access on COUNT so it can be sampled every cycle.
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h00C;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            #3;
            chk("ar_count", PRDATA, 32'(k % 4));
            chk("ar_irq", irq_o, (k >= 4));
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_wr(12'h000, 32'h4, err);          // stop, keep IRQ_EN
        apb_rd(12'h100, rd, err);
        chk("ar_status", rd, 32'h1);
        apb_rd(12'h104, rd, err);
        chk("ar_irq_raw", rd, 32'h1);
        chk("ar_irq_raw_err", err, 0);
        chk("ar_irq_ch", irq_ch_o, 32'h1);
        apb_wr(12'h100, 32'h1, err);
        #3;
        chk("ar_irq_cleared", irq_o, 0);

        // ---------------- ch1 one-shot, PRESC=2, CMP=2 ----------------
        apb_wr(12'h014, 32'd2, err);
        apb_wr(12'h018, 32'd2, err);
        apb_wr(12'h010, 32'h5, err);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h01C;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) step();
            #3;
            chk("os_count", PRDATA, (k >= 9) ? 32'd2 : 32'(k / 3));
            chk("os_irq_ch1", irq_ch_o[1], (k >= 9));
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_rd(12'h010, rd, err);
        chk("os_ctrl_en_cleared", rd, 32'h4);
        repeat (5) step();
        apb_rd(12'h01C, rd, err);
        chk("os_count_held", rd, 32'd2);

        // ---------------- ch2 W1C collides with match ----------------
        apb_wr(12'h024, 32'd0, err);
        apb_wr(12'h028, 32'd5, err);
        apb_wr(12'h020, 32'h3, err);          // matches land 6, 12, 18 edges later
        repeat (10) step();
        apb_wr(12'h100, 32'h4, err);          // access ends on the 12th edge
        apb_rd(12'h100, rd, err);
        chk("col_status_set_wins", rd, 32'h6);
        apb_wr(12'h020, 32'h0, err);
        apb_wr(12'h100, 32'h6, err);
        apb_rd(12'h100, rd, err);
        chk("col_status_cleared", rd, 32'h0);

        // ---------------- ch3 COUNT write on a tick edge ----------------
        apb_wr(12'h034, 32'd3, err);
        apb_wr(12'h038, 32'hFF, err);
        apb_wr(12'h030, 32'h1, err);          // ticks 4, 8, 12 edges later
        repeat (6) step();
        apb_wr(12'h03C, 32'h10, err);         // access ends on the 8th edge
        apb_rd(12'h03C, rd, err);
        chk("col_count_write_wins", rd, 32'h10);
        apb_wr(12'h030, 32'h0, err);

        // ---------------- error responses ----------------
        apb_rd(12'h108, rd, err);
        chk("err_rd108_slverr", err, 1);
        chk("err_rd108_data", rd, 0);
        apb_rd(12'h040, rd, err);
        chk("err_rd_ch4_slverr", err, 1);
        chk("err_rd_ch4_data", rd, 0);
        apb_wr(12'h104, 32'hF, err);
        chk("err_wr_irq_raw_slverr", err, 1);
        apb_wr(12'h048, 32'h55, err);
        chk("err_wr_ch4_slverr", err, 1);
        apb_rd(12'h100, rd, err);
        chk("err_status_unchanged", rd, 0);
        apb_rd(12'h008, rd, err);
        chk("err_cmp0_unchanged", rd, 32'd3);
        chk("err_mapped_no_slverr", err, 0);

`ifdef APB_TIMER_MC_PWM_EN
        // ---------------- PWM on ch0, CMP=2, auto-reload ----------------
        apb_wr(12'h00C, 32'd0, err);
        apb_wr(12'h008, 32'd2, err);
        apb_wr(12'h000, 32'h3, err);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            #3;
            chk("pwm_ch0", pwm_o[0], ((k % 3) != 0));
        end
        apb_wr(12'h000, 32'h0, err);
`endif

        // ---------------- reset in the middle of a write ----------------
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h018; PWDATA = 32'h77;
        step();
        PENABLE = 1'b1;
        HRESETn = 1'b0;
        step();
        step();
        HRESETn = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        step();
        #3;
        chk("rst_irq", irq_o, 0);
        chk("rst_pready", PREADY, 1);
        chk("rst_slverr", PSLVERR, 0);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_rd(12'(c * 16 + r * 4), rd, err);
                chk("rst_reg", rd, 0);
            end
        end
        apb_rd(12'h100, rd, err);
        chk("rst_status", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_timer_mc
`default_nettype wire
